event_acq_ctrl: RTL

EVENT_ACQ_CTRL -- requirements
Module: event_acq_ctrl

---
 rtl/event_acq_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/event_acq_ctrl.sv
// event_acq_ctrl
// Run controller for an event acquisition path. It arms on a start pulse,
// optionally waits for an external gate, writes one FIFO word per accepted
// trigger while running, then drains the FIFO before reporting completion.
// The FIFO is read out as an AXI-Stream source in every state, with packets
// cut at a configurable beat count or at the last word of a drain.
//
// Ports
//   clk, rstn_i              clock, synchronous active-low reset
//   start_i/stop_i/abort_i   one-cycle run control pulses
//   cfg_gate_en_i, gate_i    run only while gate_i is high when enabled
//   cfg_event_limit_i        events per run, 0 = unlimited
//   cfg_packet_size_i        beats per packet, 0 treated as 1
//   trig_i                   event strobe
//   fifo_full_i/empty_i/count_i  FIFO status (first-word-fall-through)
//   axis_tready_i            downstream ready
//   fifo_wr_en_o/rd_en_o/rst_o   FIFO controls
//   axis_tvalid_o/tlast_o    stream handshake and framing
//   state_o, busy_o, done_o  status
//   event_cnt_o, drop_cnt_o, overflow_o  per-run statistics
module event_acq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             abort_i,
  input  logic             cfg_gate_en_i,
  input  logic             gate_i,
  input  logic [31:0]      cfg_event_limit_i,
  input  logic [CNT_W-1:0] cfg_packet_size_i,
  input  logic             trig_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  input  logic [CNT_W-1:0] fifo_count_i,
  input  logic             axis_tready_i,
  output logic             fifo_wr_en_o,
  output logic             fifo_rd_en_o,
  output logic             fifo_rst_o,
  output logic             axis_tvalid_o,
  output logic             axis_tlast_o,
  output logic [2:0]       state_o,
  output logic [31:0]      event_cnt_o,
  output logic [31:0]      drop_cnt_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3
  } state_t;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  state_t           state_reg, state_next;
  logic [31:0]      event_cnt_reg, event_cnt_next;
  logic [31:0]      drop_cnt_reg, drop_cnt_next;
  logic             overflow_reg, overflow_next;
  logic             done_reg, done_next;
  logic             fifo_rst_reg, fifo_rst_next;
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic [CNT_W-1:0] size_reg, size_next;
  logic [CNT_W-1:0] eff_size;

  logic wr_accept;
  logic trig_drop;
  logic limit_hit;
  logic abort_hit;
  logic tvalid;
  logic tlast;
  logic handshake;

  // Write path: only RUN writes; a trigger on the exit cycle is still taken.
  assign wr_accept = (state_reg == RUN) && trig_i && !fifo_full_i;
  assign trig_drop = (state_reg == RUN) && trig_i && fifo_full_i;
  assign abort_hit = abort_i && (state_reg != IDLE);

  // The write that brings the count up to the limit ends the run.
  assign limit_hit = wr_accept && (cfg_event_limit_i != 32'd0) &&
                     (event_cnt_reg != CNT_SAT) &&
                     ((event_cnt_reg + 32'd1) == cfg_event_limit_i);

  always_comb begin
    state_next     = state_reg;
    event_cnt_next = event_cnt_reg;
    drop_cnt_next  = drop_cnt_reg;
    overflow_next  = overflow_reg;
    done_next      = 1'b0;
    fifo_rst_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i && !stop_i && !abort_i) begin
          state_next     = ARMED;
          event_cnt_next = 32'd0;
          drop_cnt_next  = 32'd0;
          overflow_next  = 1'b0;
        end
      end

      ARMED: begin
        if (abort_i) begin
          state_next    = IDLE;
          fifo_rst_next = 1'b1;
        end else if (stop_i) begin
          state_next = IDLE;
        end else if (!cfg_gate_en_i || gate_i) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (wr_accept && (event_cnt_reg != CNT_SAT)) begin
          event_cnt_next = event_cnt_reg + 32'd1;
        end
        if (trig_drop) begin
          overflow_next = 1'b1;
          if (drop_cnt_reg != CNT_SAT) begin
            drop_cnt_next = drop_cnt_reg + 32'd1;
          end
        end
        if (abort_i) begin
          state_next    = IDLE;
          fifo_rst_next = 1'b1;
        end else if (stop_i || (cfg_gate_en_i && !gate_i) || limit_hit) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (abort_i) begin
          state_next    = IDLE;
          fifo_rst_next = 1'b1;
        end else if (fifo_empty_i) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Readout. The packet size is captured on the first beat of each packet so
  // a configuration change never shortens or stretches a packet in flight.
  always_comb begin
    eff_size = size_reg;
    if (beat_reg == '0) begin
      eff_size = (cfg_packet_size_i == '0) ? CNT_W'(1) : cfg_packet_size_i;
    end
  end

  assign tvalid    = !fifo_empty_i;
  assign handshake = tvalid && axis_tready_i;
  assign tlast     = tvalid && ((beat_reg == (eff_size - CNT_W'(1))) ||
                                ((state_reg == DRAIN) && (fifo_count_i == CNT_W'(1))));

  always_comb begin
    beat_next = beat_reg;
    size_next = size_reg;
    if (beat_reg == '0) begin
      size_next = eff_size;
    end
    if (abort_hit) begin
      beat_next = '0;
    end else if (handshake) begin
      beat_next = tlast ? '0 : (beat_reg + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      event_cnt_reg <= 32'd0;
      drop_cnt_reg  <= 32'd0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
      fifo_rst_reg  <= 1'b1;
      beat_reg      <= '0;
      size_reg      <= CNT_W'(1);
    end else begin
      state_reg     <= state_next;
      event_cnt_reg <= event_cnt_next;
      drop_cnt_reg  <= drop_cnt_next;
      overflow_reg  <= overflow_next;
      done_reg      <= done_next;
      fifo_rst_reg  <= fifo_rst_next;
      beat_reg      <= beat_next;
      size_reg      <= size_next;
    end
  end

  assign fifo_wr_en_o  = wr_accept;
  assign fifo_rd_en_o  = handshake;
  assign fifo_rst_o    = fifo_rst_reg;
  assign axis_tvalid_o = tvalid;
  assign axis_tlast_o  = tlast;
  assign state_o       = state_reg;
  assign event_cnt_o   = event_cnt_reg;
  assign drop_cnt_o    = drop_cnt_reg;
  assign overflow_o    = overflow_reg;
  assign busy_o        = (state_reg != IDLE);
  assign done_o        = done_reg;

endmodule
